// File: rtl/period_timer_ctrl_pkg.sv
// Shared types and default widths for the period timer controller.
package period_timer_ctrl_pkg;

  localparam int unsigned CNT_BITS_DEF = 4;
  localparam int unsigned REP_BITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/period_timer_ctrl_if.sv
// Control/status bundle between a requester and the period timer controller.
interface period_timer_ctrl_if #(
  parameter int unsigned CNT_BITS = period_timer_ctrl_pkg::CNT_BITS_DEF,
  parameter int unsigned REP_BITS = period_timer_ctrl_pkg::REP_BITS_DEF
);

  logic                start;
  logic                stop;
  logic [CNT_BITS-1:0] period;
  logic [REP_BITS-1:0] reps;
  logic                busy;
  logic                tick;
  logic                done;
  logic                err;
  logic [CNT_BITS-1:0] count_out;
  logic [REP_BITS-1:0] ticks_done;

  modport master (
    output start, stop, period, reps,
    input  busy, tick, done, err, count_out, ticks_done
  );

  modport slave (
    input  start, stop, period, reps,
    output busy, tick, done, err, count_out, ticks_done
  );

endinterface

// File: rtl/period_timer_ctrl_timer_counter.sv
// Rollover counter: counts 1..rollover_val and wraps back to 1; clear wins over enable.
module timer_counter
  import period_timer_ctrl_pkg::*;
#(
  parameter int unsigned CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [CNT_BITS-1:0] rollover_val,
  output logic [CNT_BITS-1:0] count_out,
  output logic                rollover_flag
);

  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_d;
  logic                at_roll_c;

  // A zero rollover value never counts as reached.
  assign at_roll_c = (count_q == rollover_val) && (rollover_val != '0);

  // Next count value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (at_roll_c) begin
        count_d = CNT_BITS'(1);
      end else begin
        count_d = count_q + CNT_BITS'(1);
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = at_roll_c;

endmodule

// File: rtl/period_timer_ctrl.sv
// Period timer controller: runs a fixed number of periodic ticks or free-runs until stopped.
module period_timer_ctrl
  import period_timer_ctrl_pkg::*;
#(
  parameter int unsigned CNT_BITS = CNT_BITS_DEF,
  parameter int unsigned REP_BITS = REP_BITS_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  period_timer_ctrl_if.slave bus
);

  localparam logic [REP_BITS-1:0] TICKS_MAX = '1;

  state_e              state_q;
  state_e              state_d;
  logic [CNT_BITS-1:0] period_q;
  logic [CNT_BITS-1:0] period_d;
  logic [REP_BITS-1:0] reps_q;
  logic [REP_BITS-1:0] reps_d;
  logic [REP_BITS-1:0] ticks_q;
  logic [REP_BITS-1:0] ticks_d;
  logic                err_q;
  logic                err_d;

  logic                clear_c;
  logic                cnt_en_c;
  logic                rollover_c;
  logic                tick_c;
  logic [CNT_BITS-1:0] cnt_c;

  timer_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_timer_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear_c),
    .count_enable  (cnt_en_c),
    .rollover_val  (period_q),
    .count_out     (cnt_c),
    .rollover_flag (rollover_c)
  );

  // A tick is only meaningful while running; outside RUN the counter is parked.
  assign tick_c = rollover_c && (state_q == RUN);

  // Next-state and counter control.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    reps_d   = reps_q;
    ticks_d  = ticks_q;
    err_d    = 1'b0;
    clear_c  = 1'b0;
    cnt_en_c = 1'b0;

    // Tick tally saturates so free-running never wraps back to small values.
    if (tick_c && (ticks_q != TICKS_MAX)) begin
      ticks_d = ticks_q + REP_BITS'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.period != '0) begin
            period_d = bus.period;
            reps_d   = bus.reps;
            ticks_d  = '0;
            state_d  = ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ARM: begin
        clear_c = 1'b1;
        state_d = bus.stop ? IDLE : RUN;
      end
      RUN: begin
        cnt_en_c = 1'b1;
        // Stop outranks completion; the coincident tick still shows.
        if (bus.stop) begin
          clear_c = 1'b1;
          state_d = IDLE;
        end else if (tick_c && (reps_q != '0) && (ticks_d == reps_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and run-context registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      reps_q   <= '0;
      ticks_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      reps_q   <= reps_d;
      ticks_q  <= ticks_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy       = (state_q == ARM) || (state_q == RUN);
  assign bus.tick       = tick_c;
  assign bus.done       = (state_q == DONE);
  assign bus.err        = err_q;
  assign bus.count_out  = cnt_c;
  assign bus.ticks_done = ticks_q;

endmodule
